tile_sequencer: RTL and testbench
=================================

Name: tile_sequencer

Overview:
- Top-level sequencer for one systolic-array tile pass: load operand BRAM from a host stream, read it back into the compute unit, drain the array pipeline, signal completion.
- Sits between the host/DMA stream, the single-port operand BRAM and the compute-unit enable.
- Replaces free-running address generation with an explicit start/busy/done handshake.

Parameters:
- BRAM_DEPTH, 2, BRAM address width in bits; tile holds N = 2**BRAM_DEPTH words.
- DATA_WIDTH, 8, width of load data and BRAM write data.
- DRAIN_CYCLES, 4, cycles to wait after the last read before done (array pipeline depth); legal range 1..255.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately)
- start  input  1  begin a tile pass; sampled only in IDLE
- load_valid  input  1  host offers load_data this cycle
- load_data  input  DATA_WIDTH  operand word
- load_ready  output  1  sequencer accepts a load word this cycle
- bram_en  output  1  BRAM port enable
- write_mode  output  1  0 = read, 1 = write
- address  output  BRAM_DEPTH  BRAM address
- bram_wdata  output  DATA_WIDTH  BRAM write data
- enable_cu  output  1  compute-unit enable, aligned with valid BRAM read data
- compute_ready  output  1  sticky: compute data has started flowing this pass
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset=0): state=IDLE; bram_en, write_mode, address, bram_wdata, enable_cu, compute_ready, done, load_ready all 0; counters 0. Reset mid-pass aborts with no further BRAM access.
- All outputs registered except load_ready (combinational: 1 iff state==LOAD).
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE.
- IDLE: start=1 -> LOAD next cycle; load counter=0; compute_ready cleared on this transition. start in any other state ignored.
- LOAD: each accepted beat (load_valid & load_ready) produces, next cycle, bram_en=1, write_mode=1, address=beat index, bram_wdata=load_data. No beat -> bram_en=0 that cycle (gaps allowed). After beat N-1 accepted -> COMPUTE.
- COMPUTE: exactly N cycles of bram_en=1, write_mode=0, address 0..N-1 consecutively; no stalls. After address N-1 -> DRAIN.
- enable_cu = read strobe delayed 1 cycle (BRAM read latency 1): high for N consecutive cycles, starting the cycle after address 0 is driven.
- compute_ready set to 1 with the first enable_cu; holds until the next IDLE->LOAD transition or reset.
- DRAIN: DRAIN_CYCLES cycles, bram_en=0; then DONE.
- DONE: done=1 for one cycle, busy still 1; -> IDLE. start in DONE ignored.
- Address counter is BRAM_DEPTH bits; wraps N-1 -> 0 naturally at phase boundaries, never exposes wrap mid-phase.
- Outside LOAD/COMPUTE: bram_en=0, write_mode=0, address holds last value.

Optional Feature:
- Macro TILE_SEQ_STALL_EN. Defined: adds input stall (1 bit). In COMPUTE, stall=1 freezes the address counter and forces bram_en=0 that cycle; enable_cu follows the delayed strobe, so it drops one cycle later; DRAIN counter also freezes while stall=1. LOAD/IDLE/DONE ignore stall.
- Not defined: no stall port; COMPUTE and DRAIN run uninterrupted.

Test Plan:
- BRAM_DEPTH=2, start at t0, 4 back-to-back beats 0xA1..0xA4 -> writes addr 0..3 with data 0xA1..0xA4 on consecutive cycles; reads addr 0..3 next 4 cycles; enable_cu high 4 cycles, one cycle behind reads; done pulses DRAIN_CYCLES+1=5 cycles after the addr 3 read.
- Load with load_valid gaps (beat, idle, idle, beat, beat, beat) -> exactly 4 writes, addresses 0..3 in order, no extra bram_en, COMPUTE only after 4th beat.
- start held high continuously -> second pass begins only after done; compute_ready drops to 0 at the second IDLE->LOAD, re-asserts with its first enable_cu.
- reset=0 asserted mid-COMPUTE (after addr 1) -> all outputs 0 immediately (before next edge); after release, state IDLE, busy=0, no done pulse.
- TILE_SEQ_STALL_EN defined, stall=1 for 2 cycles after addr 1 read -> addr 2 read delayed 2 cycles, enable_cu count still 4, done delayed by 2 cycles.
- DRAIN_CYCLES=1 -> done exactly 2 cycles after addr N-1 read; busy falls the cycle after done.

Source files
------------

// File: rtl/tile_sequencer.sv
// Tile-pass sequencer: loads operand BRAM from a host stream, reads it back into the compute unit,
// drains the array pipeline, then pulses done. Optional TILE_SEQ_STALL_EN adds a compute/drain stall input.
module tile_sequencer #(
  parameter int unsigned BRAM_DEPTH   = 2,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef TILE_SEQ_STALL_EN
  input  logic                  stall,
`endif
  input  logic                  start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  bram_en,
  output logic                  write_mode,
  output logic [BRAM_DEPTH-1:0] address,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  output logic                  enable_cu,
  output logic                  compute_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DRAIN_W = 8;
  localparam logic [BRAM_DEPTH-1:0] LAST_ADDR  = '1;
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [BRAM_DEPTH-1:0] r_cnt;
  logic [DRAIN_W-1:0]    r_drain;
  logic                  r_bram_en;
  logic                  r_write_mode;
  logic [BRAM_DEPTH-1:0] r_address;
  logic [DATA_WIDTH-1:0] r_bram_wdata;
  logic                  r_enable_cu;
  logic                  r_compute_ready;
  logic                  r_busy;
  logic                  r_done;

  logic w_stall;
  logic w_beat;
  logic w_rd_strobe;

`ifdef TILE_SEQ_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign load_ready  = (r_state == S_LOAD);
  assign w_beat      = load_valid & load_ready;
  // Read strobe as presented to the BRAM; data is valid one cycle later.
  assign w_rd_strobe = r_bram_en & ~r_write_mode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_drain         <= '0;
      r_bram_en       <= 1'b0;
      r_write_mode    <= 1'b0;
      r_address       <= '0;
      r_bram_wdata    <= '0;
      r_enable_cu     <= 1'b0;
      r_compute_ready <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_bram_en       <= 1'b0;
      r_write_mode    <= 1'b0;
      r_done          <= 1'b0;
      r_enable_cu     <= w_rd_strobe;
      r_compute_ready <= r_compute_ready | w_rd_strobe;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state         <= S_LOAD;
            r_cnt           <= '0;
            r_busy          <= 1'b1;
            r_compute_ready <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_beat) begin
            r_bram_en    <= 1'b1;
            r_write_mode <= 1'b1;
            r_address    <= r_cnt;
            r_bram_wdata <= load_data;
            r_cnt        <= BRAM_DEPTH'(r_cnt + 1'b1);
            if (r_cnt == LAST_ADDR) r_state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          if (!w_stall) begin
            r_bram_en <= 1'b1;
            r_address <= r_cnt;
            r_cnt     <= BRAM_DEPTH'(r_cnt + 1'b1);
            if (r_cnt == LAST_ADDR) begin
              r_state <= S_DRAIN;
              r_drain <= '0;
            end
          end
        end
        // The first drain cycle overlaps the last read; done lands DRAIN_CYCLES+1 after it.
        S_DRAIN: begin
          if (!w_stall) begin
            if (r_drain == DRAIN_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_drain <= DRAIN_W'(r_drain + 1'b1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bram_en       = r_bram_en;
  assign write_mode    = r_write_mode;
  assign address       = r_address;
  assign bram_wdata    = r_bram_wdata;
  assign enable_cu     = r_enable_cu;
  assign compute_ready = r_compute_ready;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_tile_sequencer.sv
// Scoreboard bench for tile_sequencer: driver queues expected BRAM ops per pass, monitors check them.
module tb_tile_sequencer;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int AW = 2;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } op_t;

  logic clk, rst_n, start, load_valid;
  logic [7:0] load_data;
  logic load_ready, bram_en, write_mode, enable_cu, compute_ready, busy, done;
  logic [AW-1:0] address;
  logic [7:0] bram_wdata;

  logic load_ready1, bram_en1, write_mode1, enable_cu1, compute_ready1, busy1, done1;
  logic [AW-1:0] address1;
  logic [7:0] bram_wdata1;

  int total = 0;
  int bad = 0;
  int passes_done = 0;
  op_t exp_q[$];
  logic [7:0] pd[N];
  bit gap_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  tile_sequencer #(.BRAM_DEPTH(AW), .DATA_WIDTH(8), .DRAIN_CYCLES(D)) u_dut (
    .clk(clk), .reset(rst_n),
`ifdef TILE_SEQ_STALL_EN
    .stall(1'b0),
`endif
    .start(start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .bram_en(bram_en), .write_mode(write_mode),
    .address(address), .bram_wdata(bram_wdata), .enable_cu(enable_cu),
    .compute_ready(compute_ready), .busy(busy), .done(done)
  );

  // Free-running second instance with the shortest drain.
  tile_sequencer #(.BRAM_DEPTH(AW), .DATA_WIDTH(8), .DRAIN_CYCLES(1)) u_d1 (
    .clk(clk), .reset(rst_n),
`ifdef TILE_SEQ_STALL_EN
    .stall(1'b0),
`endif
    .start(1'b1), .load_valid(1'b1), .load_data(8'h5A),
    .load_ready(load_ready1), .bram_en(bram_en1), .write_mode(write_mode1),
    .address(address1), .bram_wdata(bram_wdata1), .enable_cu(enable_cu1),
    .compute_ready(compute_ready1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the main instance.
  bit  prev_rd = 0, exp_rd_next = 0, exp_cr = 0, prev_done = 0;
  int  since = -1;
  op_t e;
  bit  rd, nxt;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_rd = 0; exp_rd_next = 0; exp_cr = 0; prev_done = 0; since = -1;
    end else begin
      rd  = bram_en && !write_mode;
      nxt = 0;
      if (exp_rd_next) chk("read_streak", 32'(rd), 32'd1);
      if (bram_en) begin
        if (exp_q.size() == 0) chk("spurious_bram_en", 32'(bram_en), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("bram_write_mode", 32'(write_mode), 32'(e.wr));
          chk("bram_addr", 32'(address), 32'(e.addr));
          if (e.wr) chk("bram_wdata", 32'(bram_wdata), 32'(e.data));
          nxt = e.wr ? (e.addr == AW'(N - 1)) : (e.addr != AW'(N - 1));
          if (!e.wr && e.addr == AW'(N - 1)) since = -2;
        end
      end else if (!load_ready) chk("write_mode_idle", 32'(write_mode), 32'd0);
      exp_rd_next = nxt;
      chk("enable_cu", 32'(enable_cu), 32'(prev_rd));
      if (load_ready) exp_cr = 0;
      if (prev_rd) exp_cr = 1;
      chk("compute_ready", 32'(compute_ready), 32'(exp_cr));
      prev_rd = rd;
      if (since == -2) since = 0;
      else if (since >= 0) since++;
      chk("done_timing", 32'(done), 32'(since == D + 1));
      if (since == D + 1) begin since = -1; passes_done++; end
      if (prev_done) chk("busy_after_done", 32'(busy), 32'd0);
      if (bram_en || done) chk("busy_active", 32'(busy), 32'd1);
      prev_done = done;
    end
  end

  // Monitor for the DRAIN_CYCLES=1 instance.
  bit prev_rd1 = 0, exp_cr1 = 0, prev_done1 = 0;
  int since1 = -1;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd1 = 0; exp_cr1 = 0; prev_done1 = 0; since1 = -1;
    end else begin
      chk("d1_enable_cu", 32'(enable_cu1), 32'(prev_rd1));
      if (load_ready1) exp_cr1 = 0;
      if (prev_rd1) exp_cr1 = 1;
      chk("d1_compute_ready", 32'(compute_ready1), 32'(exp_cr1));
      if (bram_en1 && write_mode1) chk("d1_wdata", 32'(bram_wdata1), 32'h5A);
      if (since1 >= 0) since1++;
      if (bram_en1 && !write_mode1 && address1 == AW'(N - 1)) since1 = 0;
      chk("d1_done_timing", 32'(done1), 32'(since1 == 2));
      if (since1 == 2) since1 = -1;
      if (prev_done1) chk("d1_busy_after_done", 32'(busy1), 32'd0);
      prev_done1 = done1;
      prev_rd1 = bram_en1 && !write_mode1;
    end
  end

  // mode: 0 back-to-back, 1 fixed gap pattern, 2 random gaps.
  task automatic do_pass(input int mode, input bit hold, input bit abort);
    int idx = 0;
    int cyc = 0;
    int guard = 0;
    int seen;
    bit v;
    start = 1'b1;
    while (!load_ready && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    chk("load_ready_rise", 32'(load_ready), 32'd1);
    if (!hold) start = 1'b0;
    while (idx < N && cyc < 200) begin
      case (mode)
        0: v = 1'b1;
        1: v = gap_pat[cyc % 6];
        default: v = 1'($urandom_range(0, 1));
      endcase
      chk("load_ready_in_load", 32'(load_ready), 32'd1);
      load_valid = v;
      load_data  = v ? pd[idx] : 8'($urandom);
      if (v) begin
        exp_q.push_back('{wr: 1'b1, addr: AW'(idx), data: pd[idx]});
        if (idx == N - 1)
          for (int a = 0; a < N; a++) exp_q.push_back('{wr: 1'b0, addr: AW'(a), data: 8'h00});
        idx++;
      end
      @(posedge clk); #1; cyc++;
    end
    load_valid = 1'b0;
    chk("beats_accepted", 32'(idx), N);
    chk("load_ready_after_last", 32'(load_ready), 32'd0);
    if (abort) begin
      guard = 0;
      while (!(bram_en && !write_mode && address == AW'(1)) && guard < 50) begin
        @(posedge clk); #1; guard++;
      end
      chk("abort_point_reached", 32'(guard < 50), 32'd1);
      start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_bram_en", 32'(bram_en), 32'd0);
      chk("rst_write_mode", 32'(write_mode), 32'd0);
      chk("rst_address", 32'(address), 32'd0);
      chk("rst_wdata", 32'(bram_wdata), 32'd0);
      chk("rst_enable_cu", 32'(enable_cu), 32'd0);
      chk("rst_compute_ready", 32'(compute_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_load_ready", 32'(load_ready), 32'd0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      repeat (4) begin
        @(posedge clk); #1;
        chk("post_abort_busy", 32'(busy), 32'd0);
        chk("post_abort_done", 32'(done), 32'd0);
      end
    end else begin
      seen = passes_done;
      guard = 0;
      while (passes_done == seen && guard < 100) begin
        chk("no_load_before_done", 32'(load_ready), 32'd0);
        @(posedge clk); #1; guard++;
      end
      chk("done_seen", 32'(passes_done), 32'(seen + 1));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    #3;
    chk("reset_bram_en", 32'(bram_en), 32'd0);
    chk("reset_address", 32'(address), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_load_ready", 32'(load_ready), 32'd0);
    chk("reset_compute_ready", 32'(compute_ready), 32'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    pd = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    do_pass(0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) pd[i] = 8'($urandom);
    do_pass(1, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < N; i++) pd[i] = 8'($urandom);
      do_pass(2, (p < 2), 1'b0);
    end
    pd = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_pass(0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) pd[i] = 8'($urandom);
    do_pass(2, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
